// File: rtl/reed_speed_meter_if.sv
// Reed speed meter bus: raw reed and wheel size in,
// conditioned revolution pulse and speed results out.
interface reed_speed_meter_if;
  logic       reed;
  logic [7:0] circ;
  logic       rev_pulse;
  logic       moving;
  logic [6:0] speed;
  logic       speed_valid;
  logic [15:0] period;

  modport master (
    output reed, circ,
    input  rev_pulse, moving, speed,
    input  speed_valid, period
  );

  modport slave (
    input  reed, circ,
    output rev_pulse, moving, speed,
    output speed_valid, period
  );
endinterface

// File: rtl/reed_speed_meter.sv
// Reed contact conditioner, revolution period counter
// and sequential period-to-km/h divider with standstill timeout.
module reed_speed_meter #(
  parameter int F_CLK     = 2048,
  parameter int K_NUM     = 3600 * F_CLK / 100,
  parameter int K_DEN     = 1000,
  parameter int MIN_SPEED = 3,
  parameter int LOCKOUT   = 16,
  parameter int MAX_SPEED = 99
) (
  input logic               clock,
  input logic               reset_in,
  reed_speed_meter_if.slave bus
);

  localparam int          LW    = $clog2(LOCKOUT + 1);
  localparam logic [27:0] TO_K  = 28'(MIN_SPEED * K_DEN);
  localparam logic [24:0] NUM_K = 25'(K_NUM);
  localparam logic [25:0] DEN_K = 26'(K_DEN);
  localparam logic [31:0] SAT   = 32'(MAX_SPEED);
  localparam logic [6:0]  SAT7  = 7'(MAX_SPEED);

  typedef enum logic {
    IDLE,
    MEAS
  } state_t;

  state_t      state;
  logic        s1;
  logic        s2;
  logic        s2_d;
  logic [LW-1:0] lock;
  logic [15:0] cnt;
  logic [15:0] period_q;
  logic [6:0]  speed_q;
  logic        moving_q;
  logic        rev_q;
  logic        sv_q;
  logic        busy;
  logic [5:0]  step;
  logic [31:0] dq;
  logic [25:0] dd;
  logic [25:0] rem;

  logic        det;
  logic        accept;
  logic [24:0] num_w;
  logic [25:0] den_w;
  logic [27:0] to_lhs;
  logic        timeout;
  logic [15:0] cnt_inc;
  logic [26:0] sh;
  logic        ge;
  logic [25:0] sub;
  logic [6:0]  q_sat;

  assign det     = s2 & ~s2_d;
  assign accept  = det & (lock == '0);
  assign num_w   = 25'(bus.circ) * NUM_K;
  assign den_w   = 26'(cnt) * DEN_K;
  assign to_lhs  = 28'(cnt) * TO_K;
  assign timeout = to_lhs > 28'(num_w);
  assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

  // one restoring step: shift in next dividend bit, try subtract
  assign sh    = {rem, dq[31]};
  assign ge    = sh >= {1'b0, dd};
  assign sub   = sh[25:0] - dd;
  assign q_sat = (dq > SAT) ? SAT7 : dq[6:0];

  assign bus.rev_pulse   = rev_q;
  assign bus.moving      = moving_q;
  assign bus.speed       = speed_q;
  assign bus.speed_valid = sv_q;
  assign bus.period      = period_q;

  // two-flop synchronizer plus delayed copy for edge detect
  always_ff @(posedge clock or negedge reset_in) begin
    if (!reset_in) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s2_d <= 1'b0;
    end else begin
      s1   <= bus.reed;
      s2   <= s1;
      s2_d <= s2;
    end
  end

  // measurement FSM: lockout, period count, divider, timeout
  always_ff @(posedge clock or negedge reset_in) begin
    if (!reset_in) begin
      state    <= IDLE;
      lock     <= '0;
      cnt      <= '0;
      period_q <= '0;
      speed_q  <= '0;
      moving_q <= 1'b0;
      rev_q    <= 1'b0;
      sv_q     <= 1'b0;
      busy     <= 1'b0;
      step     <= '0;
      dq       <= '0;
      dd       <= '0;
      rem      <= '0;
    end else begin
      rev_q <= 1'b0;
      sv_q  <= 1'b0;
      if (accept) begin
        rev_q <= 1'b1;
        cnt   <= '0;
        lock  <= LW'(LOCKOUT);
        unique case (state)
          IDLE: begin
            moving_q <= 1'b1;
            state    <= MEAS;
            busy     <= 1'b0;
          end
          MEAS: begin
            period_q <= cnt;
            busy     <= 1'b1;
            step     <= '0;
            dq       <= {7'd0, num_w};
            dd       <= den_w;
            rem      <= '0;
          end
          default: state <= IDLE;
        endcase
      end else begin
        if (lock != '0) begin
          lock <= lock - 1'b1;
        end
        if (state == MEAS && timeout) begin
          state    <= IDLE;
          moving_q <= 1'b0;
          speed_q  <= '0;
          sv_q     <= 1'b1;
          cnt      <= '0;
          busy     <= 1'b0;
        end else begin
          cnt <= (state == MEAS) ? cnt_inc : '0;
          if (busy) begin
            if (step == 6'd32) begin
              speed_q <= q_sat;
              sv_q    <= 1'b1;
              busy    <= 1'b0;
            end else begin
              rem  <= ge ? sub : sh[25:0];
              dq   <= {dq[30:0], ge};
              step <= step + 6'd1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_reed_speed_meter.sv
// Directed bench for reed_speed_meter: reset, speeds,
// saturation, timeout, bounce and reset mid-divide.
module tb_reed_speed_meter;

  logic clock = 1'b0;
  logic reset_in;

  reed_speed_meter_if bus ();

  reed_speed_meter dut (
    .clock    (clock),
    .reset_in (reset_in),
    .bus      (bus)
  );

  always #5 clock = ~clock;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  int   rp_cnt   = 0;
  int   sv_cnt   = 0;
  int   rp_cyc   = 0;
  int   last_lat = 0;
  logic mv_first = 1'b0;
  int   r0;
  int   s0;
  bit   seen;

  always @(posedge clock) cyc <= cyc + 1;

  // event log sampled away from the active edge
  always @(negedge clock) begin
    if (bus.rev_pulse) begin
      if (rp_cnt == 0) mv_first = bus.moving;
      rp_cnt++;
      rp_cyc = cyc;
    end
    if (bus.speed_valid) begin
      sv_cnt++;
      last_lat = cyc - rp_cyc;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulses(input int n, input int p);
    for (int i = 0; i < n; i++) begin
      bus.reed = 1'b1;
      ticks(5);
      bus.reed = 1'b0;
      ticks(p - 5);
    end
  endtask

  task automatic bursts(input int n, input int p);
    for (int i = 0; i < n; i++) begin
      bus.reed = 1'b1; ticks(2);
      bus.reed = 1'b0; ticks(2);
      bus.reed = 1'b1; ticks(2);
      bus.reed = 1'b0; ticks(p - 6);
    end
  endtask

  initial begin
    reset_in = 1'b0;
    bus.reed = 1'b0;
    bus.circ = 8'd0;
    ticks(3);
    check("rst_rev", 32'(bus.rev_pulse), 0);
    check("rst_mov", 32'(bus.moving), 0);
    check("rst_spd", 32'(bus.speed), 0);
    check("rst_sv", 32'(bus.speed_valid), 0);
    check("rst_per", 32'(bus.period), 0);
    reset_in = 1'b1;
    ticks(1000);
    check("idle_rp", rp_cnt, 0);
    check("idle_sv", sv_cnt, 0);
    check("idle_mov", 32'(bus.moving), 0);
    check("idle_spd", 32'(bus.speed), 0);

    // 200-clock revolutions, 255 cm wheel
    bus.circ = 8'd255;
    r0 = rp_cnt; s0 = sv_cnt;
    pulses(4, 200);
    check("s94_rp", rp_cnt - r0, 4);
    check("s94_mv1", 32'(mv_first), 1);
    check("s94_sv", sv_cnt - s0, 3);
    check("s94_lat", last_lat, 33);
    check("s94_per", 32'(bus.period), 199);
    check("s94_spd", 32'(bus.speed), 94);
    check("s94_mov", 32'(bus.moving), 1);
    ticks(6400);
    check("s94_to_mov", 32'(bus.moving), 0);
    check("s94_to_spd", 32'(bus.speed), 0);
    check("s94_to_sv", sv_cnt - s0, 4);
    check("s94_to_per", 32'(bus.period), 199);

    // slow riding then standstill timeout
    bus.circ = 8'd200;
    s0 = sv_cnt;
    pulses(3, 1475);
    check("s10_per", 32'(bus.period), 1474);
    check("s10_spd", 32'(bus.speed), 10);
    check("s10_sv", sv_cnt - s0, 2);
    s0 = sv_cnt;
    ticks(5000);
    check("to_sv", sv_cnt - s0, 1);
    check("to_lat", last_lat, 4917);
    check("to_mov", 32'(bus.moving), 0);
    check("to_spd", 32'(bus.speed), 0);
    check("to_per", 32'(bus.period), 1474);
    r0 = rp_cnt; s0 = sv_cnt;
    pulses(1, 100);
    check("re_rp", rp_cnt - r0, 1);
    check("re_mov", 32'(bus.moving), 1);
    check("re_sv", sv_cnt - s0, 0);
    check("re_spd", 32'(bus.speed), 0);
    ticks(5000);
    check("re_to_mov", 32'(bus.moving), 0);

    // fast riding saturates the display
    bus.circ = 8'd255;
    pulses(3, 151);
    check("sat_per", 32'(bus.period), 150);
    check("sat_spd", 32'(bus.speed), 99);
    ticks(6400);

    // bouncy contact, one pulse per burst
    r0 = rp_cnt;
    bursts(4, 200);
    check("bnc_rp", rp_cnt - r0, 4);
    check("bnc_per", 32'(bus.period), 199);
    check("bnc_spd", 32'(bus.speed), 94);

    // reset while the divider is running
    r0 = rp_cnt;
    bus.reed = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clock);
      if (bus.rev_pulse) seen = 1'b1;
    end
    check("mid_rp_seen", 32'(seen), 1);
    ticks(5);
    bus.reed = 1'b0;
    ticks(5);
    reset_in = 1'b0;
    #1;
    check("mid_spd", 32'(bus.speed), 0);
    check("mid_per", 32'(bus.period), 0);
    check("mid_mov", 32'(bus.moving), 0);
    s0 = sv_cnt;
    ticks(3);
    reset_in = 1'b1;
    ticks(50);
    check("mid_nosv", sv_cnt - s0, 0);
    pulses(3, 200);
    check("post_sv", sv_cnt - s0, 2);
    check("post_per", 32'(bus.period), 199);
    check("post_spd", 32'(bus.speed), 94);
    check("post_lat", last_lat, 33);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
